vc_arbiter: RTL and testbench
=============================

VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 The block SHALL be clocked by one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be, in order:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- vc0_empty, vc1_empty  in  1  VC FIFO empty flags
- vc0_data, vc1_data  in  6  VC FIFO head words, first-word-fall-through; bit[4] selects destination (0=D0, 1=D1)
- d0_almost_full, d1_almost_full  in  1  D FIFO back-pressure
- weight0, weight1  in  2  consecutive-grant quota per VC; 0 is treated as 1
- vc0_pop, vc1_pop  out  1  combinational pop strobes
- d0_push, d1_push  out  1  registered push strobes
- data_out  out  6  registered word to D FIFOs
- active_out  out  1  registered, a grant occurred last cycle
- idle_out  out  1  registered, both VCs empty and no push pending
- error_out  out  1  registered sticky, pop attempted on an empty VC

Function
REQ-003 VCn SHALL be eligible when !vcn_empty and the D FIFO selected by vcn_data[4] has almost_full=0.
REQ-004 At most one of vc0_pop/vc1_pop SHALL be high per cycle, and only for an eligible VC.
REQ-005 The FSM SHALL have states IDLE, SERVE0 and SERVE1, with a 2-bit grant counter cnt.
REQ-006 In IDLE: if VC0 is eligible, grant VC0 and go to SERVE0; else if VC1 is eligible, grant VC1 and go to SERVE1; else stay in IDLE.
REQ-007 In SERVEn, the FSM SHALL grant VCn again while VCn is eligible and cnt+1 < max(weightn,1); cnt increments each grant.
REQ-008 The FSM SHALL switch to the other VC (cnt reset to 0, grant issued that cycle) when VCn's quota is exhausted or VCn is ineligible, and the other VC is eligible.
REQ-009 When neither VC is eligible, the FSM SHALL go to IDLE with cnt=0 and issue no pop.
REQ-010 If the quota is exhausted, the other VC is ineligible and VCn is still eligible, the FSM SHALL grant VCn and reset cnt to 1.
REQ-011 On a grant at edge t, data_out SHALL be set to the granted head and exactly one of d0_push/d1_push (per bit[4]) asserted for the cycle after t; latency is 1 cycle.
REQ-012 With no grant, d0_push=d1_push=0 and data_out SHALL hold its value.
REQ-013 An almost_full rising in the same cycle as a head arrival SHALL block that grant; the pop is evaluated on current-cycle flags only.
REQ-014 weight0/weight1 changes SHALL take effect on the next quota comparison; an in-progress cnt is not cleared.
REQ-015 error_out SHALL set if a pop is ever asserted with the matching empty=1 (defensive), and clear only on reset.
REQ-016 idle_out SHALL be 1 when vc0_empty & vc1_empty & no push in the current cycle.

Reset
REQ-017 While reset=1 at an edge: state=IDLE, cnt=0, data_out=0, pushes=0, active_out=0, idle_out=1, error_out=0.
REQ-018 vc0_pop and vc1_pop SHALL be forced to 0 while reset is high.
REQ-019 Reset asserted mid-burst SHALL drop the pending push; the first grant after reset SHALL follow IDLE priority (VC0 first).

Structure
REQ-020 The shared package SHALL hold the state encoding (IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2), the DATA_W=6 width constant and the DEST_BIT=4 index constant.
REQ-021 The eligibility and next-grant logic SHALL be one sub-module, vc_grant_logic (combinational); the FSM and output registers stay in vc_arbiter.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
- weight0=2, weight1=1, both VCs always non-empty, destinations free -> pop sequence 0,0,1,0,0,1...
- VC0 head 6'b010001 (D1), d1_almost_full=1, VC1 head 6'b000011 (D0) -> only vc1_pop; next cycle d0_push=1, data_out=6'b000011.
- Only VC1 non-empty, weight1=1, 5 cycles -> vc1_pop held high for 5 cycles; no VC0 pop.
- Both empty for 3 cycles -> no pops; idle_out=1; active_out=0; state IDLE.
- Reset asserted on the cycle after a grant -> no push the following cycle; all outputs at reset values; first post-reset grant goes to VC0.
- weight0=0 with both VCs busy -> strict alternation 0,1,0,1; error_out stays 0 throughout.

Source files
------------

// File: rtl/vc_arbiter_pkg.sv
// Shared types and constants for the two-VC weighted round-robin arbiter.
// State encoding, word width and destination-select bit live here.
package vc_arbiter_pkg;

  localparam int DATA_W   = 6;
  localparam int DEST_BIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_t;

  // A programmed weight of zero behaves as a quota of one grant.
  function automatic logic [2:0] eff_weight(input logic [1:0] w);
    return (w == 2'd0) ? 3'd1 : {1'b0, w};
  endfunction

endpackage

// File: rtl/vc_grant_logic.sv
// Combinational eligibility check and next-grant decision for the VC arbiter.
// Produces the grant strobes plus the next FSM state and burst counter.
module vc_grant_logic
  import vc_arbiter_pkg::*;
(
  input  arb_state_t state,
  input  logic [1:0] cnt,
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  input  logic       vc0_dest,
  input  logic       vc1_dest,
  input  logic       d0_almost_full,
  input  logic       d1_almost_full,
  input  logic [1:0] weight0,
  input  logic [1:0] weight1,
  output logic       grant0,
  output logic       grant1,
  output arb_state_t next_state,
  output logic [1:0] next_cnt
);

  logic elig0;
  logic elig1;
  logic exhausted0;
  logic exhausted1;

  assign elig0 = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
  assign elig1 = !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);

  // cnt counts grants beyond the first of a burst, so the quota test is cnt+1.
  assign exhausted0 = ({1'b0, cnt} + 3'd1) >= eff_weight(weight0);
  assign exhausted1 = ({1'b0, cnt} + 3'd1) >= eff_weight(weight1);

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    next_state = IDLE;
    next_cnt   = 2'd0;
    case (state)
      SERVE0: begin
        if (elig0 && !exhausted0) begin
          grant0     = 1'b1;
          next_state = SERVE0;
          next_cnt   = cnt + 2'd1;
        end else if (elig1) begin
          grant1     = 1'b1;
          next_state = SERVE1;
        end else if (elig0) begin
          grant0     = 1'b1;
          next_state = SERVE0;
          next_cnt   = 2'd1;
        end
      end
      SERVE1: begin
        if (elig1 && !exhausted1) begin
          grant1     = 1'b1;
          next_state = SERVE1;
          next_cnt   = cnt + 2'd1;
        end else if (elig0) begin
          grant0     = 1'b1;
          next_state = SERVE0;
        end else if (elig1) begin
          grant1     = 1'b1;
          next_state = SERVE1;
          next_cnt   = 2'd1;
        end
      end
      default: begin
        if (elig0) begin
          grant0     = 1'b1;
          next_state = SERVE0;
        end else if (elig1) begin
          grant1     = 1'b1;
          next_state = SERVE1;
        end
      end
    endcase
  end

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC weighted arbiter feeding two destination FIFOs: combinational pops,
// registered push/data/status outputs, FSM state held here.
module vc_arbiter
  import vc_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  input  logic [1:0]        weight0,
  input  logic [1:0]        weight1,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] data_out,
  output logic              active_out,
  output logic              idle_out,
  output logic              error_out
);

  arb_state_t state;
  arb_state_t next_state;
  logic [1:0] cnt;
  logic [1:0] next_cnt;
  logic       grant0;
  logic       grant1;

  vc_grant_logic u_grant (
    .state          (state),
    .cnt            (cnt),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_dest       (vc0_data[DEST_BIT]),
    .vc1_dest       (vc1_data[DEST_BIT]),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .weight0        (weight0),
    .weight1        (weight1),
    .grant0         (grant0),
    .grant1         (grant1),
    .next_state     (next_state),
    .next_cnt       (next_cnt)
  );

  assign vc0_pop = grant0 && !reset;
  assign vc1_pop = grant1 && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      data_out   <= '0;
      d0_push    <= 1'b0;
      d1_push    <= 1'b0;
      active_out <= 1'b0;
      idle_out   <= 1'b1;
      error_out  <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      d0_push    <= (vc0_pop && !vc0_data[DEST_BIT]) || (vc1_pop && !vc1_data[DEST_BIT]);
      d1_push    <= (vc0_pop && vc0_data[DEST_BIT]) || (vc1_pop && vc1_data[DEST_BIT]);
      active_out <= vc0_pop || vc1_pop;
      idle_out   <= vc0_empty && vc1_empty && !(d0_push || d1_push);
      // Sticky guard against ever popping an empty FIFO.
      error_out  <= error_out || (vc0_pop && vc0_empty) || (vc1_pop && vc1_empty);
      if (vc0_pop) begin
        data_out <= vc0_data;
      end else if (vc1_pop) begin
        data_out <= vc1_data;
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: directed scenarios then random traffic,
// compared against a grant/burst model built from the arbitration rules.
module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       d0_almost_full, d1_almost_full;
  logic [1:0] weight0, weight1;
  logic       vc0_pop, vc1_pop, d0_push, d1_push;
  logic [5:0] data_out;
  logic       active_out, idle_out, error_out;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: which VC owns the current burst (-1 none) and grants past the first.
  int owner = -1;
  int run   = 0;
  int exp_data = 0, exp_p0 = 0, exp_p1 = 0, exp_active = 0, exp_idle = 1;
  int obs_grant;

  always #5 clk = ~clk;

  vc_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .weight0        (weight0),
    .weight1        (weight1),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_push        (d0_push),
    .d1_push        (d1_push),
    .data_out       (data_out),
    .active_out     (active_out),
    .idle_out       (idle_out),
    .error_out      (error_out)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int weff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit eligible(input bit empty, input int data, input bit af0, input bit af1);
    return !empty && !(data[4] ? af1 : af0);
  endfunction

  task automatic applyStimulus(input bit rst, input bit e0, input bit e1,
                               input int d0, input int d1,
                               input bit af0, input bit af1,
                               input int w0, input int w1);
    bit el[2];
    int wt[2];
    int dat[2];
    int g, nown, nrun, n, o;
    reset          = rst;
    vc0_empty      = e0;
    vc1_empty      = e1;
    vc0_data       = d0[5:0];
    vc1_data       = d1[5:0];
    d0_almost_full = af0;
    d1_almost_full = af1;
    weight0        = w0[1:0];
    weight1        = w1[1:0];
    #1;
    el[0] = eligible(e0, d0, af0, af1);
    el[1] = eligible(e1, d1, af0, af1);
    wt[0] = w0; wt[1] = w1;
    dat[0] = d0 & 63; dat[1] = d1 & 63;
    g = -1; nown = owner; nrun = run;
    if (!rst) begin
      if (owner < 0) begin
        if (el[0]) begin g = 0; nown = 0; nrun = 0; end
        else if (el[1]) begin g = 1; nown = 1; nrun = 0; end
      end else begin
        n = owner; o = 1 - owner;
        if (el[n] && (run + 1 < weff(wt[n]))) begin g = n; nrun = run + 1; end
        else if (el[o]) begin g = o; nown = o; nrun = 0; end
        else if (el[n]) begin g = n; nrun = 1; end
        else begin nown = -1; nrun = 0; end
      end
    end
    obs_grant = vc0_pop ? 0 : (vc1_pop ? 1 : -1);
    checkOutput("vc0_pop", int'(vc0_pop), int'(g == 0));
    checkOutput("vc1_pop", int'(vc1_pop), int'(g == 1));
    @(posedge clk);
    if (rst) begin
      owner = -1; run = 0;
      exp_data = 0; exp_p0 = 0; exp_p1 = 0; exp_active = 0; exp_idle = 1;
    end else begin
      exp_idle   = int'(e0 && e1 && !(exp_p0 != 0 || exp_p1 != 0));
      exp_active = int'(g >= 0);
      exp_p0     = 0;
      exp_p1     = 0;
      if (g >= 0) begin
        exp_data = dat[g];
        if (dat[g][4]) exp_p1 = 1; else exp_p0 = 1;
      end
      owner = nown; run = nrun;
    end
    #1;
    checkOutput("data_out",   int'(data_out),   exp_data);
    checkOutput("d0_push",    int'(d0_push),    exp_p0);
    checkOutput("d1_push",    int'(d1_push),    exp_p1);
    checkOutput("active_out", int'(active_out), exp_active);
    checkOutput("idle_out",   int'(idle_out),   exp_idle);
    checkOutput("error_out",  int'(error_out),  0);
  endtask

  initial begin
    int pat[9];
    pat = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

    $display("[TB] reset");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 21, 42, 0, 0, 1, 1);

    $display("[TB] weighted 2:1 sequence");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 0, 32'(i * 7 + 3), 32'(i * 11 + 16), 0, 0, 2, 1);
      checkOutput($sformatf("seq%0d", i), obs_grant, pat[i]);
    end

    $display("[TB] blocked destination");
    applyStimulus(0, 0, 0, 'b010001, 'b000011, 0, 1, 1, 1);
    checkOutput("blocked_grant", obs_grant, 1);
    checkOutput("blocked_data", int'(data_out), 'b000011);
    checkOutput("blocked_d0_push", int'(d0_push), 1);

    $display("[TB] only VC1 busy");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0, 32'(i + 40), 0, 0, 1, 1);
      checkOutput($sformatf("vc1_only%0d", i), obs_grant, 1);
    end

    $display("[TB] both empty");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 5, 9, 0, 0, 1, 1);
      checkOutput($sformatf("empty_nopop%0d", i), obs_grant, -1);
    end
    checkOutput("empty_idle", int'(idle_out), 1);
    checkOutput("empty_active", int'(active_out), 0);
    checkOutput("empty_state", int'(dut.state), 0);

    $display("[TB] reset after grant");
    applyStimulus(0, 0, 0, 12, 50, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 13, 51, 0, 0, 1, 1);
    checkOutput("rst_d0_push", int'(d0_push), 0);
    checkOutput("rst_d1_push", int'(d1_push), 0);
    checkOutput("rst_idle", int'(idle_out), 1);
    applyStimulus(0, 0, 0, 14, 52, 0, 0, 1, 1);
    checkOutput("post_reset_grant", obs_grant, 0);

    $display("[TB] zero weights alternate");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 32'(i + 20), 32'(i + 30), 0, 0, 0, 0);
      checkOutput($sformatf("alt%0d", i), obs_grant, (i % 2 == 0) ? 1 : 0);
    end

    $display("[TB] random traffic");
    begin
      int w0r = 1, w1r = 2;
      for (int i = 0; i < 400; i++) begin
        if (i % 8 == 0) begin
          w0r = int'($urandom_range(0, 3));
          w1r = int'($urandom_range(0, 3));
        end
        applyStimulus($urandom_range(0, 31) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      w0r, w1r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
